// File: rtl/store_buffer.sv
// Store FIFO between MEM and data memory: queues sw/sh/sb stores, drains the oldest per cycle,
// forwards buffered full-word stores to loads and stalls loads that hit a partial store.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 11
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     st_valid,
   output logic                     st_ready,
   input  logic [31:0]              st_addr,
   input  logic [31:0]              st_data,
   input  logic [1:0]               st_option,
   input  logic [31:0]              st_pc,
   input  logic                     ld_valid,
   input  logic [31:0]              ld_addr,
   output logic                     fwd_hit,
   output logic [31:0]              fwd_data,
   output logic                     ld_stall,
   input  logic                     drain_en,
   output logic                     dm_we,
   output logic [31:0]              dm_addr,
   output logic [31:0]              dm_din,
   output logic [1:0]               dm_option,
   output logic [31:0]              dm_pc,
   input  logic                     sync_req,
   output logic                     sync_done,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      OPT_SW  = 2'b00,
      OPT_SB  = 2'b01,
      OPT_SH  = 2'b10,
      OPT_BAD = 2'b11
   } opt_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] pc;
      opt_e        option;
   } entry_t;

   entry_t           entries [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [PW-1:0]    head_ptr;
   logic [PW-1:0]    tail_ptr;
   logic             push;
   logic             pop;

   assign st_ready  = (count != CW'(DEPTH)) && !sync_req;
   assign push      = st_valid && st_ready && (opt_e'(st_option) != OPT_BAD) && !reset;
   // Gating with reset keeps a pending head from being written during the reset cycle.
   assign pop       = drain_en && (count != '0) && !reset;
   assign sync_done = sync_req && (count == '0);

   assign dm_we     = pop;
   assign dm_addr   = entries[head_ptr].addr;
   assign dm_din    = entries[head_ptr].data;
   assign dm_option = entries[head_ptr].option;
   assign dm_pc     = entries[head_ptr].pc;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         valid    <= '0;
      end else begin
         if (push) begin
            tail_ptr        <= tail_ptr + PW'(1);
            valid[tail_ptr] <= 1'b1;
         end
         if (pop) begin
            head_ptr        <= head_ptr + PW'(1);
            valid[head_ptr] <= 1'b0;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // NOTE: entry payload is not reset; the valid bits alone decide whether an entry means anything.
   always_ff @(posedge clock) begin
      if (push) begin
         entries[tail_ptr] <= '{addr: st_addr, data: st_data, pc: st_pc, option: opt_e'(st_option)};
      end
   end

   // Walk oldest to youngest from head so the last match seen is the youngest one.
   always_comb begin
      logic [PW-1:0] idx;
      // NOTE: every output of this block gets a default first so no latch is inferred.
      fwd_hit  = 1'b0;
      fwd_data = '0;
      ld_stall = 1'b0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_ptr + PW'(i);
         if (valid[idx] && (entries[idx].addr[AW+1:2] == ld_addr[AW+1:2])) begin
            fwd_hit  = (entries[idx].option == OPT_SW);
            ld_stall = (entries[idx].option != OPT_SW);
            fwd_data = (entries[idx].option == OPT_SW) ? entries[idx].data : '0;
         end
      end
      if (!ld_valid) begin
         fwd_hit  = 1'b0;
         ld_stall = 1'b0;
         fwd_data = '0;
      end
   end

   // Load address bits outside the compared word index are intentionally ignored.
   logic ld_addr_unused;
   assign ld_addr_unused = ^{ld_addr[31:AW+2], ld_addr[1:0]};

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: one task per scenario, hand-computed expectations.
module tb_store_buffer;

   logic        clock = 1'b0;
   logic        reset;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [1:0]  st_option;
   logic [31:0] st_pc;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic        ld_stall;
   logic        drain_en;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_din;
   logic [1:0]  dm_option;
   logic [31:0] dm_pc;
   logic        sync_req;
   logic        sync_done;
   logic [2:0]  count;

   int errors = 0;
   int checks = 0;

   store_buffer #(.DEPTH(4), .AW(11)) dut (
      .clock(clock), .reset(reset),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
      .st_option(st_option), .st_pc(st_pc),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .ld_stall(ld_stall), .drain_en(drain_en),
      .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_option(dm_option), .dm_pc(dm_pc),
      .sync_req(sync_req), .sync_done(sync_done), .count(count)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] o);
      st_valid  = 1'b1;
      st_addr   = a;
      st_data   = d;
      st_option = o;
      st_pc     = 32'h1000 + a;
   endtask

   task automatic clear_inputs();
      reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_option = '0; st_pc = '0;
      ld_valid = 1'b0; ld_addr = '0; drain_en = 1'b0; sync_req = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      #1;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
      checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready: got %b want 1", st_ready); end
      checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL reset_dm_we: got %b want 0", dm_we); end
      checks++; if (sync_done !== 1'b0) begin errors++; $display("FAIL reset_sync_done: got %b want 0", sync_done); end
      ld_valid = 1'b1; ld_addr = 32'h10;
      #1;
      checks++; if ({fwd_hit, ld_stall} !== 2'b00) begin errors++; $display("FAIL reset_fwd: got %b want 00", {fwd_hit, ld_stall}); end
      ld_valid = 1'b0;
   endtask

   task automatic test_single_sw();
      drain_en = 1'b1;
      drive_store(32'h10, 32'hDEADBEEF, 2'b00);
      #1;
      checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL single_same_cycle_we: got %b want 0", dm_we); end
      tick();
      st_valid = 1'b0;
      #1;
      checks++; if (dm_we !== 1'b1) begin errors++; $display("FAIL single_dm_we: got %b want 1", dm_we); end
      checks++; if (dm_addr !== 32'h10) begin errors++; $display("FAIL single_dm_addr: got %h want 00000010", dm_addr); end
      checks++; if (dm_din !== 32'hDEADBEEF) begin errors++; $display("FAIL single_dm_din: got %h want deadbeef", dm_din); end
      checks++; if (dm_option !== 2'b00) begin errors++; $display("FAIL single_dm_option: got %b want 00", dm_option); end
      checks++; if (dm_pc !== 32'h1010) begin errors++; $display("FAIL single_dm_pc: got %h want 00001010", dm_pc); end
      tick();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count_after: got %0d want 0", count); end
      checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL single_we_after: got %b want 0", dm_we); end
      drain_en = 1'b0;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         drive_store(32'(4 * i), 32'hA0 + 32'(i), 2'b00);
         #1;
         checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b want 1", i, st_ready); end
         tick();
      end
      st_valid = 1'b0;
      #1;
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", count); end
      checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_full: got %b want 0", st_ready); end
      drive_store(32'h40, 32'hFFFF0000, 2'b00);
      tick();
      st_valid = 1'b0;
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_fifth_ignored: got %0d want 4", count); end
      drain_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (count !== 3'(4 - i)) begin errors++; $display("FAIL drain_count_%0d: got %0d want %0d", i, count, 4 - i); end
         checks++; if ({dm_we, dm_addr, dm_din} !== {1'b1, 32'(4 * i), 32'hA0 + 32'(i)}) begin
            errors++; $display("FAIL drain_order_%0d: got we=%b addr=%h din=%h want we=1 addr=%h din=%h",
                               i, dm_we, dm_addr, dm_din, 32'(4 * i), 32'hA0 + 32'(i));
         end
         tick();
      end
      checks++; if ({count, dm_we} !== 4'b0000) begin errors++; $display("FAIL drain_empty: got count=%0d we=%b want 0 0", count, dm_we); end
      drain_en = 1'b0;
   endtask

   task automatic test_forward();
      drive_store(32'h20, 32'h11111111, 2'b00); tick();
      drive_store(32'h20, 32'h22222222, 2'b00); tick();
      st_valid = 1'b0;
      ld_valid = 1'b1; ld_addr = 32'h20;
      #1;
      checks++; if ({fwd_hit, ld_stall} !== 2'b10) begin errors++; $display("FAIL fwd_youngest_flags: got %b want 10", {fwd_hit, ld_stall}); end
      checks++; if (fwd_data !== 32'h22222222) begin errors++; $display("FAIL fwd_youngest_data: got %h want 22222222", fwd_data); end
      ld_addr = 32'h24;
      #1;
      checks++; if ({fwd_hit, ld_stall} !== 2'b00) begin errors++; $display("FAIL fwd_miss: got %b want 00", {fwd_hit, ld_stall}); end
      ld_valid = 1'b0; ld_addr = 32'h20;
      #1;
      checks++; if ({fwd_hit, ld_stall} !== 2'b00) begin errors++; $display("FAIL fwd_no_ld_valid: got %b want 00", {fwd_hit, ld_stall}); end
      drive_store(32'h21, 32'h000000EE, 2'b01); tick();
      st_valid = 1'b0;
      ld_valid = 1'b1;
      #1;
      checks++; if ({fwd_hit, ld_stall} !== 2'b01) begin errors++; $display("FAIL fwd_younger_sb: got %b want 01", {fwd_hit, ld_stall}); end
      ld_valid = 1'b0;
      drain_en = 1'b1;
      tick(); tick(); tick();
      drain_en = 1'b0;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL fwd_drained: got %0d want 0", count); end
   endtask

   task automatic test_partial_stall();
      drive_store(32'h32, 32'h0000ABCD, 2'b10); tick();
      st_valid = 1'b0;
      ld_valid = 1'b1; ld_addr = 32'h30;
      #1;
      checks++; if ({fwd_hit, ld_stall} !== 2'b01) begin errors++; $display("FAIL sh_stall: got %b want 01", {fwd_hit, ld_stall}); end
      tick();
      checks++; if (ld_stall !== 1'b1) begin errors++; $display("FAIL sh_stall_held: got %b want 1", ld_stall); end
      drain_en = 1'b1;
      #1;
      checks++; if ({dm_we, dm_addr, dm_option, ld_stall} !== {1'b1, 32'h32, 2'b10, 1'b1}) begin
         errors++; $display("FAIL sh_drain: got we=%b addr=%h opt=%b stall=%b want 1 00000032 10 1",
                            dm_we, dm_addr, dm_option, ld_stall);
      end
      tick();
      checks++; if ({fwd_hit, ld_stall} !== 2'b00) begin errors++; $display("FAIL sh_stall_clear: got %b want 00", {fwd_hit, ld_stall}); end
      ld_valid = 1'b0; drain_en = 1'b0;
   endtask

   task automatic test_push_pop();
      drive_store(32'h100, 32'h1, 2'b00); tick();
      drive_store(32'h104, 32'h2, 2'b00); tick();
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL pp_count_pre: got %0d want 2", count); end
      drive_store(32'h108, 32'h3, 2'b00);
      drain_en = 1'b1;
      #1;
      checks++; if ({dm_we, dm_addr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL pp_first: got we=%b addr=%h want 1 00000100", dm_we, dm_addr); end
      tick();
      st_valid = 1'b0;
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL pp_count_same: got %0d want 2", count); end
      checks++; if (dm_addr !== 32'h104) begin errors++; $display("FAIL pp_second: got %h want 00000104", dm_addr); end
      tick();
      checks++; if ({dm_we, dm_addr, dm_din} !== {1'b1, 32'h108, 32'h3}) begin
         errors++; $display("FAIL pp_third: got we=%b addr=%h din=%h want 1 00000108 00000003", dm_we, dm_addr, dm_din);
      end
      tick();
      drain_en = 1'b0;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL pp_empty: got %0d want 0", count); end
   endtask

   task automatic test_back_to_back();
      int nxt = 0;
      int pushed = 0;
      drain_en = 1'b1;
      for (int cyc = 0; cyc < 20 && nxt < 6; cyc++) begin
         if (pushed < 6) begin
            drive_store(32'h200 + 32'(4 * pushed), 32'h5000 + 32'(pushed), 2'b00);
            pushed++;
         end else begin
            st_valid = 1'b0;
         end
         #1;
         if (dm_we) begin
            checks++; if ({dm_addr, dm_din} !== {32'h200 + 32'(4 * nxt), 32'h5000 + 32'(nxt)}) begin
               errors++; $display("FAIL b2b_order_%0d: got addr=%h din=%h want addr=%h din=%h",
                                  nxt, dm_addr, dm_din, 32'h200 + 32'(4 * nxt), 32'h5000 + 32'(nxt));
            end
            nxt++;
         end
         tick();
      end
      st_valid = 1'b0; drain_en = 1'b0;
      checks++; if (nxt != 6) begin errors++; $display("FAIL b2b_write_count: got %0d want 6", nxt); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_empty: got %0d want 0", count); end
   endtask

   task automatic test_illegal();
      drive_store(32'h300, 32'h77, 2'b11);
      tick();
      st_valid = 1'b0;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL illegal_no_push: got %0d want 0", count); end
      drain_en = 1'b1;
      #1;
      checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL illegal_no_write: got %b want 0", dm_we); end
      drain_en = 1'b0;
   endtask

   task automatic test_sync();
      int pulses = 0;
      bit done_seen = 0;
      for (int i = 0; i < 3; i++) begin
         drive_store(32'h400 + 32'(4 * i), 32'(i), 2'b00);
         tick();
      end
      st_valid = 1'b0;
      sync_req = 1'b1;
      #1;
      checks++; if ({st_ready, sync_done} !== 2'b00) begin errors++; $display("FAIL sync_ready: got %b want 00", {st_ready, sync_done}); end
      drive_store(32'h500, 32'h9, 2'b00);
      tick();
      st_valid = 1'b0;
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL sync_blocks_push: got %0d want 3", count); end
      drain_en = 1'b1;
      for (int cyc = 0; cyc < 10 && !done_seen; cyc++) begin
         #1;
         if (sync_done) done_seen = 1;
         if (dm_we) pulses++;
         tick();
      end
      checks++; if (pulses != 3) begin errors++; $display("FAIL sync_pulses: got %0d want 3", pulses); end
      checks++; if (!done_seen || sync_done !== 1'b1 || count !== 3'd0) begin
         errors++; $display("FAIL sync_done: got seen=%b done=%b count=%0d want 1 1 0", done_seen, sync_done, count);
      end
      sync_req = 1'b0;
      #1;
      checks++; if (sync_done !== 1'b0) begin errors++; $display("FAIL sync_release: got %b want 0", sync_done); end
      drain_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      drive_store(32'h600, 32'hAA, 2'b00); tick();
      drive_store(32'h604, 32'hBB, 2'b00); tick();
      st_valid = 1'b0;
      drain_en = 1'b1;
      reset = 1'b1;
      #1;
      checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL rst_mid_no_write: got %b want 0", dm_we); end
      tick();
      reset = 1'b0;
      #1;
      checks++; if ({count, dm_we, st_ready} !== 5'b00001) begin
         errors++; $display("FAIL rst_mid_state: got count=%0d we=%b ready=%b want 0 0 1", count, dm_we, st_ready);
      end
      drain_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_sw();
      test_fill();
      test_forward();
      test_partial_stall();
      test_push_pop();
      test_back_to_back();
      test_illegal();
      test_sync();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
